stitch_pipeline_elastic: RTL
============================

# stitch_pipeline_elastic

Parametrised, flow-controlled successor to the fixed-depth stitched stage pipeline: NUM_STAGES register slices, each fed by a combinational stage function, joined by a valid/ready handshake with per-stage bubble collapsing, synchronous flush and an occupancy counter. It sits between a producer and a consumer as the top-level shell around generated per-cycle stage logic. Unlike the free-running stitched wrapper, it stalls under back-pressure, tracks in-flight items and has a defined reset state.

## Interface
- NUM_STAGES, 2, pipeline depth (register slices); legal range 1..16
- DATA_WIDTH, 32, payload width in bits; legal range 1..256
- STAGE_INC, 0, constant each stage adds to its input, modulo 2^DATA_WIDTH
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of all in-flight items
- in_valid  input  1  producer offers in_data
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  DATA_WIDTH  payload
- out_valid  output  1  out_data holds a result
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  DATA_WIDTH  result
- occupancy  output  OCC_W = clog2(NUM_STAGES+1)  number of valid slices

## Operation
- Slice k (0..NUM_STAGES-1) holds valid_k and data_k; slice 0 is fed from in_data, slice k from slice k-1.
- Stage function: stage k presents (upstream data + STAGE_INC) mod 2^DATA_WIDTH to the input of slice k; result = in_data + NUM_STAGES*STAGE_INC, truncated to DATA_WIDTH.
- Per-slice ready: ready_k = !valid_k || ready_{k+1}; ready_NUM_STAGES = out_ready. Bubbles collapse: an empty slice loads even when downstream is stalled.
- Slice k loads (valid_k <= upstream valid, data_k <= stage output) when ready_k; otherwise it holds.
- in_ready = ready_0 && !flush; out_valid = valid_{NUM_STAGES-1} && !flush; out_data = data_{NUM_STAGES-1}.
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready. Data stay stable while out_valid && !out_ready.
- flush: all valid_k <= 0 next cycle; no input or output handshake completes in the flush cycle; data registers keep their values.
- occupancy: registered count of set valid_k. Updates +1 on input handshake only, -1 on output handshake only, unchanged on both or neither, 0 on flush or rst. Never exceeds NUM_STAGES.
- rst: all valid_k <= 0, all data_k <= 0, occupancy <= 0. rst has priority over flush; both abort all in-flight items with no output.

## Timing
- Latency: an item accepted at cycle t with no stall is presented on out_valid in cycle t+NUM_STAGES.
- Throughput: one item per cycle while out_ready is held high.
- in_ready depends combinationally on out_ready through the ready chain; no combinational path from in_valid to out_valid.
- After rst deassertion: out_valid=0, out_data=0, occupancy=0; in_ready=1 unless flush is asserted.
- Full: when all slices are valid and out_ready=0, in_ready=0. When full and out_ready=1, a new input is accepted in the same cycle.

## Structure
- Package stitch_pipeline_pkg: OCC_W helper function clog2(NUM_STAGES+1) and the default constants for depth, width and increment.
- Sub-module stitch_pipeline_stage: one register slice plus its stage function, with ports valid/ready/data on both sides. The top instantiates NUM_STAGES copies in a generate loop and owns the occupancy counter and flush gating.

## Test plan
- Streaming: NUM_STAGES=3, STAGE_INC=1, out_ready=1. Inputs 10, 11, 12 on consecutive cycles -> outputs 13, 14, 15 at t+3, t+4, t+5; occupancy peaks at 3.
- Back-pressure: NUM_STAGES=2, out_ready=0, offer 4 items -> 2 items accepted, in_ready=0, occupancy=2. Raise out_ready -> items emerge in order, none lost or duplicated.
- Bubble collapse: NUM_STAGES=4, one item, then out_ready=0 while a second item is offered 2 cycles later -> the second item advances until it is adjacent to the first; occupancy=2.
- Flush: NUM_STAGES=3 with 3 items in flight, flush for 1 cycle together with in_valid=1 -> in_ready=0, out_valid=0 that cycle, occupancy=0 next cycle, no stale output ever appears.
- Reset mid-stream: rst asserted with occupancy=2 -> next cycle out_valid=0, out_data=0, occupancy=0. A new input then appears after exactly NUM_STAGES cycles.
- Wrap: DATA_WIDTH=8, NUM_STAGES=2, STAGE_INC=200, input 0 -> output 144 ((400) mod 256).

Source files
------------

// File: rtl/stitch_pipeline_pkg.sv
// Shared defaults and width helpers for the elastic stitched stage pipeline.
package stitch_pipeline_pkg;

    localparam int          DEF_NUM_STAGES = 2;
    localparam int          DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_STAGE_INC  = 0;

    // Occupancy must be able to represent 0..n inclusive.
    function automatic int occ_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stitch_pipeline_stage.sv
// One register slice fed by its combinational stage function, with a
// valid/ready handshake on both sides and bubble-collapsing ready.
module stitch_pipeline_stage
    import stitch_pipeline_pkg::*;
#(
    parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned STAGE_INC  = DEF_STAGE_INC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_data
);

    localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(STAGE_INC);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] stage_out;

    assign stage_out = up_data + INC;

    // An empty slice always accepts, so bubbles are squeezed out under stall.
    assign up_ready = !valid_q || dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (up_ready) begin
            valid_q <= up_valid;
            data_q  <= stage_out;
        end
    end

endmodule

// File: rtl/stitch_pipeline_elastic.sv
// Flow-controlled stitched pipeline: NUM_STAGES elastic slices in a chain,
// with flush gating at both ends and a registered occupancy counter.
module stitch_pipeline_elastic
    import stitch_pipeline_pkg::*;
#(
    parameter int          NUM_STAGES = DEF_NUM_STAGES,
    parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned STAGE_INC  = DEF_STAGE_INC
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [occ_w(NUM_STAGES)-1:0]     occupancy
);

    localparam int OCC_W = occ_w(NUM_STAGES);

    // Index k is the upstream side of slice k; index NUM_STAGES is the output.
    logic [NUM_STAGES:0]                 vld_pipe;
    logic [NUM_STAGES:0]                 rdy_pipe;
    logic [NUM_STAGES:0][DATA_WIDTH-1:0] dat_pipe;
    logic                                in_fire;
    logic                                out_fire;

    assign vld_pipe[0]          = in_valid;
    assign dat_pipe[0]          = in_data;
    assign rdy_pipe[NUM_STAGES] = out_ready;

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            stitch_pipeline_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .STAGE_INC  (STAGE_INC)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .up_valid (vld_pipe[k]),
                .up_ready (rdy_pipe[k]),
                .up_data  (dat_pipe[k]),
                .dn_valid (vld_pipe[k+1]),
                .dn_ready (rdy_pipe[k+1]),
                .dn_data  (dat_pipe[k+1])
            );
        end
    endgenerate

    assign in_ready  = rdy_pipe[0] && !flush;
    assign out_valid = vld_pipe[NUM_STAGES] && !flush;
    assign out_data  = dat_pipe[NUM_STAGES];

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule
